// File: rtl/dc_arb_pkg.sv
// dc_arb_pkg: FSM state type, grant-id width helper and one-hot rotate shared by the write arbiter
package dc_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int NUM_REQ_DEF = 4;
  localparam int GID_W_DEF = $clog2(NUM_REQ_DEF);
  function automatic int gid_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [63:0] rotl1(input logic [63:0] v, input int w);
    return ((v << 1) | (v >> (w - 1))) & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/dc_rr_arbiter.sv
// dc_rr_arbiter: combinational round-robin pick; req/rr_ptr in, win (first set at or after rr_ptr) and any out
module dc_rr_arbiter #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] win,
  output logic          any
);
  logic [2*N-1:0] rot;
  int off;
  int sum;
  always_comb begin
    rot = {req, req} >> rr_ptr;
    off = 0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? i : off;
    sum = int'(rr_ptr) + off;
    win = IW'(sum >= N ? sum - N : sum);
  end
  assign any = |req;
endmodule

// File: rtl/dc_write_arbiter.sv
// dc_write_arbiter: write-domain round-robin FIFO writer; clk/rstn(async low), req_valid/req_data/req_last/req_ready, fifo_full in, fifo_wr_en/fifo_wr_data/write_pointer/grant_valid/grant_id out; DC_WRITE_ARB_BURST_LOCK_EN holds grant until req_last
module dc_write_arbiter
  import dc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [BUFFER_DEPTH-1:0]       write_pointer,
  output logic                          grant_valid,
  output logic [gid_w(NUM_REQ)-1:0]     grant_id
);
  localparam int IW = gid_w(NUM_REQ);
  state_t state;
  logic [IW-1:0] rr_ptr, win;
  logic any, accept, rel;
  dc_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (.req(req_valid), .rr_ptr(rr_ptr), .win(win), .any(any));
  assign grant_valid = state == GRANT;
  assign accept = grant_valid & req_valid[grant_id] & ~fifo_full;
`ifdef DC_WRITE_ARB_BURST_LOCK_EN
  assign rel = accept & req_last[grant_id];
`else
  assign rel = accept;
`endif
  assign req_ready = (grant_valid && !fifo_full) ? NUM_REQ'(1) << grant_id : '0;
  assign fifo_wr_en = accept;
  assign fifo_wr_data = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      grant_id <= '0;
      rr_ptr <= '0;
      write_pointer <= BUFFER_DEPTH'(1);
    end else begin
      if (state == IDLE && any) begin
        state <= GRANT;
        grant_id <= win;
      end
      if (rel) begin
        state <= IDLE;
        rr_ptr <= grant_id == IW'(NUM_REQ - 1) ? '0 : grant_id + IW'(1);
      end
      if (accept) write_pointer <= BUFFER_DEPTH'(rotl1(64'(write_pointer), BUFFER_DEPTH));
    end
  end
endmodule
